tlb_search_engine: RTL and testbench

- Parametrised, multi-cycle TLB lookup engine that holds its own entry array.
- It replaces the single-entry combinational hit judges used by the IMMU and DMMU.
- Serves I-side (execute) and D-side (load/store) requests through one valid/ready request and response interface.
- Scans LANES entries per cycle and returns hit, index, RPN and a BookE exception code. Software-side entry writes and invalidate-all use a separate port.

---
 rtl/tlb_search_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_tlb_search_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_search_engine.sv
// Multi-cycle TLB lookup engine: owns the entry array and scans LANES entries per cycle.
// Optional macro TLB_MULTIHIT_DET_EN: full scan with multiple-match detection on multi_hit.
module tlb_search_engine #(
    parameter int ENTRIES = 16,
    parameter int LANES   = 4,
    parameter int EPN_W   = 20,
    parameter int RPN_W   = 20,
    parameter int TID_W   = 8,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [1:0]       req_mode,
    input  logic             req_as,
    input  logic             req_pr,
    input  logic [EPN_W-1:0] req_epn,
    input  logic [TID_W-1:0] pid0,
    input  logic [TID_W-1:0] pid1,
    input  logic [TID_W-1:0] pid2,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [RPN_W-1:0] rsp_rpn,
    output logic [4:0]       rsp_exc,
    input  logic             wr_en,
    output logic             wr_rdy,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_v,
    input  logic             wr_ts,
    input  logic [TID_W-1:0] wr_tid,
    input  logic [EPN_W-1:0] wr_epn,
    input  logic [RPN_W-1:0] wr_rpn,
    input  logic [5:0]       wr_perm,
    input  logic             inv_all,
    output logic             multi_hit
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(ENTRIES - LANES);
    localparam logic [4:0] EXC_DSI  = 5'd2;
    localparam logic [4:0] EXC_ISI  = 5'd3;
    localparam logic [4:0] EXC_DTLB = 5'd13;
    localparam logic [4:0] EXC_ITLB = 5'd14;

    logic [1:0]       state_reg;
    logic [ENTRIES-1:0] ent_v_reg;
    logic             ent_ts_reg   [ENTRIES];
    logic [TID_W-1:0] ent_tid_reg  [ENTRIES];
    logic [EPN_W-1:0] ent_epn_reg  [ENTRIES];
    logic [RPN_W-1:0] ent_rpn_reg  [ENTRIES];
    logic [5:0]       ent_perm_reg [ENTRIES];

    logic [1:0]       mode_reg;
    logic             as_reg, pr_reg;
    logic [EPN_W-1:0] epn_reg;
    logic [TID_W-1:0] pid0_reg, pid1_reg, pid2_reg;
    logic [IDX_W-1:0] g_base_reg;

    logic             rsp_hit_reg;
    logic [IDX_W-1:0] rsp_idx_reg;
    logic [RPN_W-1:0] rsp_rpn_reg;
    logic [4:0]       rsp_exc_reg;

    logic [LANES-1:0] lane_hit;
    logic [IDX_W-1:0] grp_lo;
    logic             grp_any;
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [5:0]       cand_perm;
    logic             granted;
    logic             scan_end;
    logic             is_fetch;
    logic             res_hit;
    logic [4:0]       res_exc;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IDX_W-1:0] lane_ent;
            logic             tid_ok;
            assign lane_ent = g_base_reg + IDX_W'(gi);
            assign tid_ok   = (ent_tid_reg[lane_ent] == '0) || (ent_tid_reg[lane_ent] == pid0_reg) ||
                              (ent_tid_reg[lane_ent] == pid1_reg) || (ent_tid_reg[lane_ent] == pid2_reg);
            assign lane_hit[gi] = ent_v_reg[lane_ent] && (ent_ts_reg[lane_ent] == as_reg) &&
                                  tid_ok && (ent_epn_reg[lane_ent] == epn_reg);
        end
    endgenerate

    // Descending walk leaves the lowest matching lane in grp_lo.
    always_comb begin
        grp_lo = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_hit[i]) grp_lo = IDX_W'(i);
        end
    end
    assign grp_any = |lane_hit;

`ifdef TLB_MULTIHIT_DET_EN
    logic             found_reg;
    logic [IDX_W-1:0] win_idx_reg;
    logic             multi_reg;
    logic             multi_hit_reg;
    logic             grp_multi;
    logic             cand_multi;

    assign grp_multi  = (lane_hit & (lane_hit - LANES'(1))) != '0;
    assign cand_found = found_reg | grp_any;
    assign cand_idx   = found_reg ? win_idx_reg : (g_base_reg + grp_lo);
    assign cand_multi = multi_reg | grp_multi | (found_reg & grp_any);
    assign scan_end   = (g_base_reg == LAST_BASE);
    assign multi_hit  = multi_hit_reg;
`else
    assign cand_found = grp_any;
    assign cand_idx   = g_base_reg + grp_lo;
    assign scan_end   = grp_any || (g_base_reg == LAST_BASE);
    assign multi_hit  = 1'b0;
`endif

    // Entries never change outside IDLE, so the winner's fields are read back by index.
    assign cand_perm = ent_perm_reg[cand_idx];
    assign is_fetch  = (mode_reg == 2'd0);

    always_comb begin
        case (mode_reg)
            2'd0:    granted = pr_reg ? cand_perm[0] : cand_perm[1];
            2'd2:    granted = pr_reg ? cand_perm[2] : cand_perm[3];
            default: granted = pr_reg ? cand_perm[4] : cand_perm[5];
        endcase
    end

    assign res_hit = cand_found & granted;
    assign res_exc = !cand_found ? (is_fetch ? EXC_ITLB : EXC_DTLB) :
                     granted     ? 5'd0 : (is_fetch ? EXC_ISI : EXC_DSI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            ent_v_reg   <= '0;
            mode_reg    <= '0;
            as_reg      <= 1'b0;
            pr_reg      <= 1'b0;
            epn_reg     <= '0;
            pid0_reg    <= '0;
            pid1_reg    <= '0;
            pid2_reg    <= '0;
            g_base_reg  <= '0;
            rsp_hit_reg <= 1'b0;
            rsp_idx_reg <= '0;
            rsp_rpn_reg <= '0;
            rsp_exc_reg <= '0;
`ifdef TLB_MULTIHIT_DET_EN
            found_reg     <= 1'b0;
            win_idx_reg   <= '0;
            multi_reg     <= 1'b0;
            multi_hit_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (inv_all) ent_v_reg <= '0;
                    else if (wr_en) ent_v_reg[wr_idx] <= wr_v;
                    if (req_vld) begin
                        mode_reg   <= req_mode;
                        as_reg     <= req_as;
                        pr_reg     <= req_pr;
                        epn_reg    <= req_epn;
                        pid0_reg   <= pid0;
                        pid1_reg   <= pid1;
                        pid2_reg   <= pid2;
                        g_base_reg <= '0;
                        state_reg  <= ST_SCAN;
`ifdef TLB_MULTIHIT_DET_EN
                        found_reg  <= 1'b0;
                        multi_reg  <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (scan_end) begin
                        state_reg   <= ST_DONE;
                        rsp_hit_reg <= res_hit;
                        rsp_idx_reg <= cand_found ? cand_idx : '0;
                        rsp_rpn_reg <= res_hit ? ent_rpn_reg[cand_idx] : '0;
                        rsp_exc_reg <= res_exc;
                    end else begin
                        g_base_reg <= g_base_reg + IDX_W'(LANES);
                    end
`ifdef TLB_MULTIHIT_DET_EN
                    found_reg   <= cand_found;
                    win_idx_reg <= cand_idx;
                    multi_reg   <= cand_multi;
                    if (scan_end) multi_hit_reg <= cand_multi;
`endif
                end
                ST_DONE: begin
                    if (rsp_rdy) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Payload fields carry no reset; only V is meaningful after reset.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && wr_en && !inv_all) begin
            ent_ts_reg[wr_idx]   <= wr_ts;
            ent_tid_reg[wr_idx]  <= wr_tid;
            ent_epn_reg[wr_idx]  <= wr_epn;
            ent_rpn_reg[wr_idx]  <= wr_rpn;
            ent_perm_reg[wr_idx] <= wr_perm;
        end
    end

    assign req_rdy = (state_reg == ST_IDLE);
    assign wr_rdy  = req_rdy;
    assign rsp_vld = (state_reg == ST_DONE);
    assign rsp_hit = rsp_hit_reg;
    assign rsp_idx = rsp_idx_reg;
    assign rsp_rpn = rsp_rpn_reg;
    assign rsp_exc = rsp_exc_reg;

endmodule

// File: tb/tb_tlb_search_engine.sv
// Bench for tlb_search_engine: directed cases plus random traffic against a brute-force TLB model.
module tb_tlb_search_engine;
    localparam int ENTRIES = 16;
    localparam int LANES   = 4;
    localparam int GROUPS  = ENTRIES / LANES;

    logic        clk, rst_n;
    logic        req_vld, req_rdy, req_as, req_pr;
    logic [1:0]  req_mode;
    logic [19:0] req_epn;
    logic [7:0]  pid0, pid1, pid2;
    logic        rsp_vld, rsp_rdy, rsp_hit, multi_hit;
    logic [3:0]  rsp_idx;
    logic [19:0] rsp_rpn;
    logic [4:0]  rsp_exc;
    logic        wr_en, wr_rdy, wr_v, wr_ts, inv_all;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_tid;
    logic [19:0] wr_epn, wr_rpn;
    logic [5:0]  wr_perm;

    tlb_search_engine dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_mode(req_mode), .req_as(req_as),
        .req_pr(req_pr), .req_epn(req_epn), .pid0(pid0), .pid1(pid1), .pid2(pid2),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
        .rsp_rpn(rsp_rpn), .rsp_exc(rsp_exc),
        .wr_en(wr_en), .wr_rdy(wr_rdy), .wr_idx(wr_idx), .wr_v(wr_v), .wr_ts(wr_ts),
        .wr_tid(wr_tid), .wr_epn(wr_epn), .wr_rpn(wr_rpn), .wr_perm(wr_perm),
        .inv_all(inv_all), .multi_hit(multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference TLB contents.
    bit        m_v    [ENTRIES];
    bit        m_ts   [ENTRIES];
    bit [7:0]  m_tid  [ENTRIES];
    bit [19:0] m_epn  [ENTRIES];
    bit [19:0] m_rpn  [ENTRIES];
    bit [5:0]  m_perm [ENTRIES];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_wr(input logic [3:0] idx, input logic v, input logic ts, input logic [7:0] tid,
                            input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] perm,
                            input bit upd);
        wr_idx = idx; wr_v = v; wr_ts = ts; wr_tid = tid;
        wr_epn = epn; wr_rpn = rpn; wr_perm = perm; wr_en = 1'b1;
        if (upd) begin
            m_v[idx] = v; m_ts[idx] = ts; m_tid[idx] = tid;
            m_epn[idx] = epn; m_rpn[idx] = rpn; m_perm[idx] = perm;
        end
    endtask

    task automatic do_write(input logic [3:0] idx, input logic v, input logic ts, input logic [7:0] tid,
                            input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] perm);
        drive_wr(idx, v, ts, tid, epn, rpn, perm, 1'b1);
        @(negedge clk);
        wr_en = 1'b0;
        $display("write idx=%0d v=%0b ts=%0b tid=%0h epn=%h rpn=%h perm=%b", idx, v, ts, tid, epn, rpn, perm);
    endtask

    // Called right after a negedge; any write already on the wires commits on the accept edge.
    task automatic lookup(input logic [1:0] mode, input logic as_i, input logic pr_i, input logic [19:0] epn,
                          input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input int hold);
        int first, nmatch, lat, e_lat;
        bit allowed, fetch, e_hit, e_multi;
        bit [3:0] e_idx;
        bit [19:0] e_rpn;
        bit [4:0] e_exc;
        bit [5:0] pm;
        first = -1; nmatch = 0; allowed = 0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (m_v[e] && m_ts[e] == as_i && (m_tid[e] == 0 || m_tid[e] == p0 || m_tid[e] == p1 ||
                m_tid[e] == p2) && m_epn[e] == epn) begin
                nmatch++;
                if (first < 0) first = e;
            end
        end
        fetch = (mode == 2'd0);
        if (first >= 0) begin
            pm = m_perm[first];  // {SR,UR,SW,UW,SX,UX}
            if (fetch)            allowed = pr_i ? pm[0] : pm[1];
            else if (mode == 2'd2) allowed = pr_i ? pm[2] : pm[3];
            else                   allowed = pr_i ? pm[4] : pm[5];
        end
        e_hit = (first >= 0) && allowed;
        e_idx = (first >= 0) ? 4'(first) : 4'd0;
        e_rpn = e_hit ? m_rpn[first] : 20'd0;
        if (first < 0)   e_exc = fetch ? 5'd14 : 5'd13;
        else if (allowed) e_exc = 5'd0;
        else             e_exc = fetch ? 5'd3 : 5'd2;
`ifdef TLB_MULTIHIT_DET_EN
        e_lat = GROUPS + 1;
        e_multi = (nmatch >= 2);
`else
        e_lat = (first >= 0) ? first / LANES + 2 : GROUPS + 1;
        e_multi = 1'b0;
`endif
        req_mode = mode; req_as = as_i; req_pr = pr_i; req_epn = epn;
        pid0 = p0; pid1 = p1; pid2 = p2; req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0; wr_en = 1'b0; inv_all = 1'b0;
        lat = 1;
        while (!rsp_vld && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("lookup mode=%0d as=%0b pr=%0b epn=%h -> vld=%0b hit=%0b idx=%0d rpn=%h exc=%0d multi=%0b lat=%0d",
                 mode, as_i, pr_i, epn, rsp_vld, rsp_hit, rsp_idx, rsp_rpn, rsp_exc, multi_hit, lat);
        chk("rsp_vld_timeout", 32'(rsp_vld), 32'd1);
        chk("latency", 32'(lat), 32'(e_lat));
        chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
        chk("rsp_idx", 32'(rsp_idx), 32'(e_idx));
        chk("rsp_rpn", 32'(rsp_rpn), 32'(e_rpn));
        chk("rsp_exc", 32'(rsp_exc), 32'(e_exc));
        chk("multi_hit", 32'(multi_hit), 32'(e_multi));
        for (int c = 0; c < hold; c++) begin
            // A write attempted while busy must be ignored; the model is left unchanged.
            if (c == 0) drive_wr(e_idx, 1'b0, 1'b1, 8'hFF, 20'h0, 20'h0, 6'h0, 1'b0);
            @(posedge clk); #1;
            chk("hold_vld", 32'(rsp_vld), 32'd1);
            chk("hold_rdy", 32'(req_rdy), 32'd0);
            chk("hold_idx", 32'(rsp_idx), 32'(e_idx));
            chk("hold_exc", 32'(rsp_exc), 32'(e_exc));
            chk("hold_rpn", 32'(rsp_rpn), 32'(e_rpn));
        end
        wr_en = 1'b0;
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk("rel_vld", 32'(rsp_vld), 32'd0);
        chk("rel_rdy", 32'(req_rdy), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_vld = 0; req_mode = 0; req_as = 0; req_pr = 0; req_epn = 0;
        pid0 = 0; pid1 = 0; pid2 = 0; rsp_rdy = 0;
        wr_en = 0; wr_idx = 0; wr_v = 0; wr_ts = 0; wr_tid = 0; wr_epn = 0; wr_rpn = 0; wr_perm = 0;
        inv_all = 0;
        for (int e = 0; e < ENTRIES; e++) m_v[e] = 0;
        #20;
        chk("rst_req_rdy", 32'(req_rdy), 32'd1);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
        chk("rst_rsp_rpn", 32'(rsp_rpn), 32'd0);
        chk("rst_rsp_exc", 32'(rsp_exc), 32'd0);
        chk("rst_multi", 32'(multi_hit), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        lookup(2'd1, 0, 1, 20'h12345, 8'd0, 8'd0, 8'd0, 0);
        do_write(4'd9, 1, 0, 8'h00, 20'h12345, 20'hABCDE, 6'b110000);
        lookup(2'd1, 0, 1, 20'h12345, 8'd0, 8'd0, 8'd0, 0);
        lookup(2'd2, 0, 1, 20'h12345, 8'd0, 8'd0, 8'd0, 0);
        do_write(4'd9, 1, 0, 8'h05, 20'h12345, 20'hABCDE, 6'b110000);
        lookup(2'd0, 0, 1, 20'h12345, 8'd1, 8'd2, 8'd3, 0);
        lookup(2'd0, 0, 1, 20'h12345, 8'd1, 8'd5, 8'd3, 0);
        do_write(4'd2, 1, 0, 8'h00, 20'h0BEEF, 20'h00222, 6'b111111);
        do_write(4'd3, 1, 0, 8'h00, 20'h0BEEF, 20'h00333, 6'b111111);
        do_write(4'd12, 1, 0, 8'h00, 20'h0BEEF, 20'h00CCC, 6'b111111);
        lookup(2'd1, 0, 0, 20'h0BEEF, 8'd0, 8'd0, 8'd0, 7);
        lookup(2'd1, 0, 0, 20'h0BEEF, 8'd0, 8'd0, 8'd0, 0);
        lookup(2'd3, 0, 1, 20'h0BEEF, 8'd0, 8'd0, 8'd0, 0);

        // inv_all wins over a simultaneous write.
        inv_all = 1'b1;
        drive_wr(4'd5, 1, 0, 8'h00, 20'h00777, 20'h00555, 6'b111111, 1'b0);
        @(negedge clk);
        inv_all = 1'b0; wr_en = 1'b0;
        for (int e = 0; e < ENTRIES; e++) m_v[e] = 0;
        lookup(2'd1, 0, 0, 20'h00777, 8'd0, 8'd0, 8'd0, 0);
        lookup(2'd1, 0, 0, 20'h0BEEF, 8'd0, 8'd0, 8'd0, 0);

        // Reset in the middle of a scan.
        do_write(4'd14, 1, 1, 8'h00, 20'h00abc, 20'h00def, 6'b111111);
        req_mode = 2'd1; req_as = 1'b1; req_epn = 20'h00abc; req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midscan_rst_vld", 32'(rsp_vld), 32'd0);
        chk("midscan_rst_rdy", 32'(req_rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < ENTRIES; e++) m_v[e] = 0;
        @(posedge clk); #1;
        chk("post_rst_vld", 32'(rsp_vld), 32'd0);
        chk("post_rst_rdy", 32'(req_rdy), 32'd1);
        @(negedge clk);
        lookup(2'd1, 1, 0, 20'h00abc, 8'd0, 8'd0, 8'd0, 0);

        // Random traffic on a small EPN/TID space so matches and multi-matches are common.
        for (int it = 0; it < 80; it++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 40) begin
                do_write(4'($urandom_range(15)), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                         8'($urandom_range(3)), 20'(20'h100 + $urandom_range(3)), 20'($urandom),
                         6'($urandom));
            end else begin
                if (r < 55)
                    drive_wr(4'($urandom_range(15)), 1'b1, 1'($urandom_range(1)), 8'($urandom_range(3)),
                             20'(20'h100 + $urandom_range(3)), 20'($urandom), 6'($urandom), 1'b1);
                lookup(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                       20'(20'h100 + $urandom_range(3)), 8'($urandom_range(3)), 8'($urandom_range(3)),
                       8'($urandom_range(3)), int'($urandom_range(2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
